// File: rtl/counter_pkg.sv
// Shared BCD digit definitions for the cascaded decade counter.
package counter_pkg;
    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // Out-of-range load nibbles saturate at 9 so the count stays pure BCD.
    function automatic bcd_digit_t clamp_bcd(input bcd_digit_t nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction
endpackage

// File: rtl/decade_digit.sv
// One decade (0..9) digit with clear/load/step and a direction-aware terminal flag.
module decade_digit
    import counter_pkg::*;
(
    input  logic             clockIn,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] loadNibble,
    input  logic             step,
    input  logic             up,
    output logic [BCD_W-1:0] value,
    output logic             terminal
);

    assign terminal = up ? (value == BCD_MAX) : (value == BCD_MIN);

    always_ff @(posedge clockIn) begin
        if (reset || clear) begin
            value <= BCD_MIN;
        end else if (load) begin
            value <= clamp_bcd(loadNibble);
        end else if (step) begin
            if (up)
                value <= (value == BCD_MAX) ? BCD_MIN : value + 4'd1;
            else
                value <= (value == BCD_MIN) ? BCD_MAX : value - 4'd1;
        end
    end

endmodule

// File: rtl/cascaded_bcd_counter.sv
// Multi-digit up/down BCD counter; digits cascade through a ripple step-enable chain.
module cascaded_bcd_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clockIn,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  hold,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   loadValue,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  carryOut,
    output logic                  overflow
);

    logic              step_base;
    logic              wrap;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] terminal;

    assign step_base = enable & ~hold;
    // A full-range wrap is a step arriving while every digit sits at its terminal value.
    assign wrap      = step_base & (&terminal);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign step[i] = step_base;
        end else begin : g_rest
            assign step[i] = step_base & (&terminal[i-1:0]);
        end

        decade_digit u_digit (
            .clockIn    (clockIn),
            .reset      (reset),
            .clear      (clear),
            .load       (load),
            .loadNibble (loadValue[i*BCD_W +: BCD_W]),
            .step       (step[i]),
            .up         (up),
            .value      (bcdOut[i*BCD_W +: BCD_W]),
            .terminal   (terminal[i])
        );
    end

    always_ff @(posedge clockIn) begin
        if (reset || clear || load) begin
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            carryOut <= wrap;
            if (wrap)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cascaded_bcd_counter.sv
// Directed self-checking bench for cascaded_bcd_counter at DIGITS=4.
module tb_cascaded_bcd_counter;

    logic        clockIn = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        up = 1'b1;
    logic        hold = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] loadValue = '0;
    logic [15:0] bcdOut;
    logic        carryOut;
    logic        overflow;

    int unsigned tests = 0;
    int unsigned failed = 0;

    cascaded_bcd_counter #(.DIGITS(4)) dut (
        .clockIn   (clockIn),
        .reset     (reset),
        .enable    (enable),
        .up        (up),
        .hold      (hold),
        .clear     (clear),
        .load      (load),
        .loadValue (loadValue),
        .bcdOut    (bcdOut),
        .carryOut  (carryOut),
        .overflow  (overflow)
    );

    always #5 clockIn = ~clockIn;

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] exp_bcd,
                               input logic exp_carry, input logic exp_ovf);
        check({tag, "_bcd"}, bcdOut, exp_bcd);
        check({tag, "_carry"}, {15'd0, carryOut}, {15'd0, exp_carry});
        check({tag, "_ovf"}, {15'd0, overflow}, {15'd0, exp_ovf});
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1;
        loadValue = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        // Reset and basic up count
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_state("reset", 16'h0000, 1'b0, 1'b0);

        enable = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("count12_carry", {15'd0, carryOut}, 16'd0);
        end
        enable = 1'b0;
        check_state("count12", 16'h0012, 1'b0, 1'b0);

        // Up cascade and wrap
        do_load(16'h9998);
        check_state("load9998", 16'h9998, 1'b0, 1'b0);
        enable = 1'b1;
        tick();
        check_state("up9999", 16'h9999, 1'b0, 1'b0);
        tick();
        check_state("upwrap", 16'h0000, 1'b1, 1'b1);
        enable = 1'b0;
        tick();
        check_state("upwrap_after", 16'h0000, 1'b0, 1'b1);

        // Down borrow
        do_load(16'h1000);
        check_state("load1000", 16'h1000, 1'b0, 1'b0);
        up = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_state("borrow", 16'h0999, 1'b0, 1'b0);

        // Down wrap
        do_load(16'h0000);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check_state("downwrap", 16'h9999, 1'b1, 1'b1);
        tick();
        check_state("downwrap_after", 16'h9999, 1'b0, 1'b1);

        // Direction change on the fly: one step down then one up
        enable = 1'b1;
        tick();
        check("dir_down", bcdOut, 16'h9998);
        up = 1'b1;
        tick();
        enable = 1'b0;
        check_state("dir_up", 16'h9999, 1'b0, 1'b1);

        // Clear beats enable
        do_load(16'h0456);
        check("load0456", bcdOut, 16'h0456);
        enable = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b0;
        check_state("clear_vs_enable", 16'h0000, 1'b0, 1'b0);

        // Load beats enable, nibbles clamped
        enable = 1'b1;
        do_load(16'h0A3F);
        enable = 1'b0;
        check_state("load_clamp", 16'h0939, 1'b0, 1'b0);

        // Hold freezes counting
        hold = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_bcd", bcdOut, 16'h0939);
        end
        hold = 1'b0;
        enable = 1'b0;
        check_state("hold_end", 16'h0939, 1'b0, 1'b0);

        // Count through a wrap to 0x0077 with enable held high, then reset mid-count
        do_load(16'h9999);
        enable = 1'b1;
        up = 1'b1;
        for (int i = 0; i < 78; i++) tick();
        check_state("count77", 16'h0077, 1'b0, 1'b1);
        reset = 1'b1;
        #3;
        check("reset_sync", bcdOut, 16'h0077);
        tick();
        check_state("reset_mid", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        check_state("after_reset", 16'h0001, 1'b0, 1'b0);
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
